// File: rtl/nn_cfg_loader_pkg.sv
// Shared definitions for the configuration loader: FSM states, opcodes,
// header field offsets and default sizes of the MNIST layer configuration.
package nn_cfg_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_HDR_LAYER  = 3'd1,
    S_HDR_NEURON = 3'd2,
    S_HDR_CNT_H  = 3'd3,
    S_HDR_CNT_L  = 3'd4,
    S_DATA_H     = 3'd5,
    S_DATA_L     = 3'd6,
    S_CHK        = 3'd7
  } cfg_state_t;

  localparam logic [7:0] OPC_WEIGHT = 8'hA5;
  localparam logic [7:0] OPC_BIAS   = 8'h5B;

  // Byte offsets of the header fields within a frame.
  localparam int FLD_OPCODE = 0;
  localparam int FLD_LAYER  = 1;
  localparam int FLD_NEURON = 2;
  localparam int FLD_CNT_H  = 3;
  localparam int FLD_CNT_L  = 4;
  localparam int HDR_BYTES  = 5;

  // Four layers; the widest layer consumes one 28x28 input image per neuron.
  localparam int NUM_LAYERS_DEF = 4;
  localparam int MAX_WORDS_DEF  = 28 * 28;

endpackage

// File: rtl/nn_cfg_hdr_check.sv
// Combinational header legality check: rejects a frame whose layer or word
// count cannot be loaded for the given record type.
module nn_cfg_hdr_check
  import nn_cfg_loader_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int MAX_WORDS  = MAX_WORDS_DEF
) (
  input  logic        is_bias,
  input  logic [7:0]  layer,
  input  logic [15:0] count,
  output logic        reject
);

  always_comb begin
    reject = 1'b0;
    if (layer == 8'd0 || 32'(layer) > NUM_LAYERS) reject = 1'b1;
    if (count == 16'd0) reject = 1'b1;
    // A bias record carries exactly one word; a weight record at most one array.
    if (is_bias && count != 16'd1) reject = 1'b1;
    if (!is_bias && 32'(count) > MAX_WORDS) reject = 1'b1;
  end

endmodule

// File: rtl/nn_cfg_loader.sv
// Byte-serial frame decoder driving the shared weight/bias config buses.
// Optional trailing checksum byte per frame when CFG_CHECKSUM_EN is defined.
module nn_cfg_loader
  import nn_cfg_loader_pkg::*;
#(
  parameter int         DATA_WIDTH = 16,
  parameter int         NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int         MAX_WORDS  = MAX_WORDS_DEF,
  parameter logic [7:0] OP_WEIGHT  = OPC_WEIGHT,
  parameter logic [7:0] OP_BIAS    = OPC_BIAS
) (
  input  logic                  clk,
  input  logic                  wb_rst_n,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] weightValue,
  output logic                  weightValid,
  output logic [DATA_WIDTH-1:0] biasValue,
  output logic                  biasValid,
  output logic [DATA_WIDTH-1:0] config_layer_num,
  output logic [DATA_WIDTH-1:0] config_neuron_num,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_err
);

  // Handshake: a byte transfers on any cycle with in_valid && in_ready; the
  // loader never backpressures, so in_ready is permanently high.
  cfg_state_t  state;
  logic        is_bias;
  logic [7:0]  layer_q;
  logic [7:0]  cnt_hi;
  logic [7:0]  data_hi;
  logic [15:0] word_cnt;
  logic [15:0] count_in;
  logic [15:0] word_in;
  logic        reject;
  logic        accept;

  assign in_ready = 1'b1;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != S_IDLE);
  assign count_in = {cnt_hi, in_byte};
  assign word_in  = {data_hi, in_byte};

  nn_cfg_hdr_check #(
    .NUM_LAYERS (NUM_LAYERS),
    .MAX_WORDS  (MAX_WORDS)
  ) u_hdr_check (
    .is_bias (is_bias),
    .layer   (layer_q),
    .count   (count_in),
    .reject  (reject)
  );

`ifdef CFG_CHECKSUM_EN
  logic [7:0] chk_acc;

  // Running XOR restarts on every byte seen in IDLE (the opcode position).
  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      chk_acc <= 8'd0;
    end else if (accept) begin
      chk_acc <= (state == S_IDLE) ? in_byte : (chk_acc ^ in_byte);
    end
  end
`endif

  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state             <= S_IDLE;
      is_bias           <= 1'b0;
      layer_q           <= 8'd0;
      cnt_hi            <= 8'd0;
      data_hi           <= 8'd0;
      word_cnt          <= 16'd0;
      weightValue       <= '0;
      weightValid       <= 1'b0;
      biasValue         <= '0;
      biasValid         <= 1'b0;
      config_layer_num  <= '0;
      config_neuron_num <= '0;
      frame_done        <= 1'b0;
      frame_err         <= 1'b0;
    end else begin
      weightValid <= 1'b0;
      biasValid   <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      if (accept) begin
        unique case (state)
          S_IDLE: begin
            if (in_byte == OP_WEIGHT || in_byte == OP_BIAS) begin
              is_bias <= (in_byte == OP_BIAS);
              state   <= S_HDR_LAYER;
            end else begin
              frame_err <= 1'b1;
            end
          end
          S_HDR_LAYER: begin
            layer_q <= in_byte;
            state   <= S_HDR_NEURON;
          end
          S_HDR_NEURON: begin
            config_layer_num  <= DATA_WIDTH'(layer_q);
            config_neuron_num <= DATA_WIDTH'(in_byte);
            state             <= S_HDR_CNT_H;
          end
          S_HDR_CNT_H: begin
            cnt_hi <= in_byte;
            state  <= S_HDR_CNT_L;
          end
          S_HDR_CNT_L: begin
            if (reject) begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
            end else begin
              word_cnt <= count_in;
              state    <= S_DATA_H;
            end
          end
          S_DATA_H: begin
            data_hi <= in_byte;
            state   <= S_DATA_L;
          end
          S_DATA_L: begin
            if (is_bias) begin
              biasValue <= DATA_WIDTH'(word_in);
              biasValid <= 1'b1;
            end else begin
              weightValue <= DATA_WIDTH'(word_in);
              weightValid <= 1'b1;
            end
            if (word_cnt == 16'd1) begin
`ifdef CFG_CHECKSUM_EN
              state <= S_CHK;
`else
              frame_done <= 1'b1;
              state      <= S_IDLE;
`endif
            end else begin
              word_cnt <= word_cnt - 16'd1;
              state    <= S_DATA_H;
            end
          end
`ifdef CFG_CHECKSUM_EN
          S_CHK: begin
            // Words were already delivered; a bad checksum is only flagged.
            if (in_byte == chk_acc) frame_done <= 1'b1;
            else                    frame_err  <= 1'b1;
            state <= S_IDLE;
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nn_cfg_loader.sv
// Bench for nn_cfg_loader: table of framed vectors, hand sequences for
// back-to-back/reset cases, and random frame streams against a parser model.
module tb_nn_cfg_loader;
  import nn_cfg_loader_pkg::*;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_byte = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] weightValue, biasValue, config_layer_num, config_neuron_num;
  logic          weightValid, biasValid, busy, frame_done, frame_err;

  always #5 clk = ~clk;

  nn_cfg_loader #(.DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .wb_rst_n          (rst_n),
    .in_byte           (in_byte),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .weightValue       (weightValue),
    .weightValid       (weightValid),
    .biasValue         (biasValue),
    .biasValid         (biasValid),
    .config_layer_num  (config_layer_num),
    .config_neuron_num (config_neuron_num),
    .busy              (busy),
    .frame_done        (frame_done),
    .frame_err         (frame_err)
  );

  int checks = 0;
  int errors = 0;

  // Observations collected by the monitor
  logic [15:0] got_w_q[$];
  logic [15:0] got_b_q[$];
  int got_done, got_err, viol, strobe_total, done_at;

  // Expectations from the reference parser
  logic [15:0] exp_w_q[$];
  logic [15:0] exp_b_q[$];
  int exp_done, exp_err;
  logic [15:0] exp_layer, exp_neuron;

  logic [7:0] stream_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (weightValid) got_w_q.push_back(weightValue);
      if (biasValid) got_b_q.push_back(biasValue);
      if (weightValid || biasValid) strobe_total++;
      if (frame_done) begin
        got_done++;
        done_at = strobe_total;
      end
      if (frame_err) got_err++;
      if (weightValid && biasValid) viol++;
      if (!in_ready) viol++;
`ifndef CFG_CHECKSUM_EN
      if (frame_done && !(weightValid || biasValid)) viol++;
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic clear_obs();
    got_w_q.delete(); got_b_q.delete();
    got_done = 0; got_err = 0; viol = 0; strobe_total = 0; done_at = -1;
    exp_w_q.delete(); exp_b_q.delete();
    exp_done = 0; exp_err = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_layer = 16'd0;
    exp_neuron = 16'd0;
  endtask

  // gap: 0 none, 1 one idle cycle before every byte, 2 random idle cycles
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    if (gap == 1) n = 1;
    else if (gap == 2 && $urandom_range(0, 3) == 0) n = int'($urandom_range(1, 2));
    repeat (n) begin
      in_valid = 1'b0;
      in_byte = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_byte = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [7:0] xor_all(input logic [7:0] f[$]);
    logic [7:0] x;
    x = 8'd0;
    foreach (f[i]) x ^= f[i];
    return x;
  endfunction

  // Reference parser: walks a complete byte stream frame by frame.
  task automatic model_stream(input logic [7:0] s[$]);
    int i, n, cnt;
    logic [7:0] op, lay, neu, x;
    logic [15:0] w;
    bit legal;
    i = 0;
    n = s.size();
    while (i < n) begin
      op = s[i];
      if (op != 8'hA5 && op != 8'h5B) begin
        exp_err++;
        i++;
        continue;
      end
      lay = s[i+1];
      neu = s[i+2];
      cnt = int'({s[i+3], s[i+4]});
      x = op ^ lay ^ neu ^ s[i+3] ^ s[i+4];
      i += 5;
      exp_layer = 16'(lay);
      exp_neuron = 16'(neu);
      legal = (lay >= 8'd1) && (lay <= 8'd4) && (cnt != 0) &&
              ((op == 8'h5B) ? (cnt == 1) : (cnt <= 784));
      if (!legal) begin
        exp_err++;
        continue;
      end
      for (int k = 0; k < cnt; k++) begin
        w = {s[i], s[i+1]};
        x = x ^ s[i] ^ s[i+1];
        i += 2;
        if (op == 8'h5B) exp_b_q.push_back(w);
        else exp_w_q.push_back(w);
      end
`ifdef CFG_CHECKSUM_EN
      if (s[i] == x) exp_done++;
      else exp_err++;
      i++;
`else
      exp_done++;
`endif
    end
  endtask

  // kind: 0 weight, 1 bias, 2 bad opcode, 3 bad layer, 4 bad count, 5 bad checksum
  task automatic gen_frame(input int kind, input int max_cnt);
    logic [7:0] f[$];
    logic [7:0] op, lay, x;
    int cnt;
    op = (kind == 1 || (kind >= 3 && $urandom_range(0, 1) == 1)) ? 8'h5B : 8'hA5;
    lay = 8'($urandom_range(1, 4));
    cnt = (op == 8'h5B) ? 1 : int'($urandom_range(1, max_cnt));
    if (kind == 2) begin
      do x = 8'($urandom); while (x == 8'hA5 || x == 8'h5B);
      f.push_back(x);
    end else begin
      if (kind == 3) lay = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(5, 255));
      if (kind == 4) begin
        if ($urandom_range(0, 1) == 1) cnt = 0;
        else if (op == 8'h5B) cnt = int'($urandom_range(2, 9));
        else cnt = int'($urandom_range(785, 65535));
      end
      f.push_back(op); f.push_back(lay); f.push_back(8'($urandom));
      f.push_back(8'(cnt >> 8)); f.push_back(8'(cnt));
      if (kind <= 1 || kind == 5) begin
        for (int k = 0; k < 2 * cnt; k++) f.push_back(8'($urandom));
`ifdef CFG_CHECKSUM_EN
        x = xor_all(f);
        if (kind == 5) x ^= 8'(1 << $urandom_range(0, 7));
        f.push_back(x);
`endif
      end
    end
    foreach (f[i]) stream_q.push_back(f[i]);
  endtask

  task automatic run_stream(input string tag, input int gap);
    clear_obs();
    model_stream(stream_q);
    foreach (stream_q[i]) send(stream_q[i], gap);
    idle(3);
    check({tag, "_n_weight"}, 32'(got_w_q.size()), 32'(exp_w_q.size()));
    check({tag, "_n_bias"}, 32'(got_b_q.size()), 32'(exp_b_q.size()));
    while (got_w_q.size() > 0 && exp_w_q.size() > 0)
      check({tag, "_weight"}, 32'(got_w_q.pop_front()), 32'(exp_w_q.pop_front()));
    while (got_b_q.size() > 0 && exp_b_q.size() > 0)
      check({tag, "_bias"}, 32'(got_b_q.pop_front()), 32'(exp_b_q.pop_front()));
    check({tag, "_done"}, 32'(got_done), 32'(exp_done));
    check({tag, "_err"}, 32'(got_err), 32'(exp_err));
    check({tag, "_layer"}, 32'(config_layer_num), 32'(exp_layer));
    check({tag, "_neuron"}, 32'(config_neuron_num), 32'(exp_neuron));
    check({tag, "_viol"}, 32'(viol), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    stream_q.delete();
  endtask

  typedef struct {
    logic [7:0]  b[11];
    int          len;
    bit          chk;
    int          gap;
    int          n_w;
    int          n_b;
    int          n_done;
    int          n_err;
    logic [15:0] layer;
    logic [15:0] neuron;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [7:0] f1[$];
    logic [7:0] f2[$];
    logic [7:0] cur[$];
    logic [15:0] w;

    vecs[0] = '{b: '{8'hA5, 8'h02, 8'h07, 8'h00, 8'h03, 8'h12, 8'h34, 8'hFF, 8'hFE, 8'h00, 8'h01},
                len: 11, chk: 1, gap: 0, n_w: 3, n_b: 0, n_done: 1, n_err: 0, layer: 2, neuron: 7};
    vecs[1] = '{b: '{8'h5B, 8'h04, 8'h09, 8'h00, 8'h01, 8'h80, 8'h00, 0, 0, 0, 0},
                len: 7, chk: 1, gap: 1, n_w: 0, n_b: 1, n_done: 1, n_err: 0, layer: 4, neuron: 9};
    vecs[2] = '{b: '{8'h33, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                len: 1, chk: 0, gap: 0, n_w: 0, n_b: 0, n_done: 0, n_err: 1, layer: 4, neuron: 9};
    vecs[3] = '{b: '{8'hA5, 8'h05, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0, 0, 0},
                len: 5, chk: 0, gap: 0, n_w: 0, n_b: 0, n_done: 0, n_err: 1, layer: 5, neuron: 0};
    vecs[4] = '{b: '{8'h5B, 8'h01, 8'h00, 8'h00, 8'h02, 0, 0, 0, 0, 0, 0},
                len: 5, chk: 0, gap: 0, n_w: 0, n_b: 0, n_done: 0, n_err: 1, layer: 1, neuron: 0};
    vecs[5] = '{b: '{8'hA5, 8'h01, 8'h00, 8'h03, 8'h11, 0, 0, 0, 0, 0, 0},
                len: 5, chk: 0, gap: 0, n_w: 0, n_b: 0, n_done: 0, n_err: 1, layer: 1, neuron: 0};
    vecs[6] = '{b: '{8'hA5, 8'h01, 8'h03, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0},
                len: 5, chk: 0, gap: 0, n_w: 0, n_b: 0, n_done: 0, n_err: 1, layer: 1, neuron: 3};
    vecs[7] = '{b: '{8'hA5, 8'h00, 8'h06, 8'h00, 8'h01, 0, 0, 0, 0, 0, 0},
                len: 5, chk: 0, gap: 0, n_w: 0, n_b: 0, n_done: 0, n_err: 1, layer: 0, neuron: 6};
    vecs[8] = '{b: '{8'h5B, 8'h03, 8'h02, 8'h00, 8'h01, 8'hAB, 8'hCD, 0, 0, 0, 0},
                len: 7, chk: 1, gap: 2, n_w: 0, n_b: 1, n_done: 1, n_err: 0, layer: 3, neuron: 2};

    // Reset state
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_weightValid", 32'(weightValid), 32'd0);
    check("rst_biasValid", 32'(biasValid), 32'd0);
    check("rst_weightValue", 32'(weightValue), 32'd0);
    check("rst_biasValue", 32'(biasValue), 32'd0);
    check("rst_layer", 32'(config_layer_num), 32'd0);
    check("rst_neuron", 32'(config_neuron_num), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_err", 32'({frame_done, frame_err}), 32'd0);

    // Table-driven vectors
    foreach (vecs[v]) begin
      clear_obs();
      cur.delete();
      for (int i = 0; i < vecs[v].len; i++) cur.push_back(vecs[v].b[i]);
`ifdef CFG_CHECKSUM_EN
      if (vecs[v].chk) cur.push_back(xor_all(cur));
`endif
      foreach (cur[i]) send(cur[i], vecs[v].gap);
      idle(3);
      check("tbl_n_weight", 32'(got_w_q.size()), 32'(vecs[v].n_w));
      check("tbl_n_bias", 32'(got_b_q.size()), 32'(vecs[v].n_b));
      for (int k = 0; k < vecs[v].n_w + vecs[v].n_b; k++) begin
        w = {vecs[v].b[5 + 2*k], vecs[v].b[6 + 2*k]};
        if (vecs[v].n_w > 0 && got_w_q.size() > 0) check("tbl_weight", 32'(got_w_q.pop_front()), 32'(w));
        if (vecs[v].n_b > 0 && got_b_q.size() > 0) check("tbl_bias", 32'(got_b_q.pop_front()), 32'(w));
      end
      check("tbl_done", 32'(got_done), 32'(vecs[v].n_done));
      check("tbl_err", 32'(got_err), 32'(vecs[v].n_err));
      check("tbl_layer", 32'(config_layer_num), 32'(vecs[v].layer));
      check("tbl_neuron", 32'(config_neuron_num), 32'(vecs[v].neuron));
      check("tbl_viol", 32'(viol), 32'd0);
`ifndef CFG_CHECKSUM_EN
      if (vecs[v].n_done > 0) check("tbl_done_with_last_strobe", 32'(done_at), 32'(vecs[v].n_w + vecs[v].n_b));
`endif
    end
    exp_layer = 16'd3;
    exp_neuron = 16'd2;

    // Back-to-back weight frames; config must switch only after NEURON byte
    clear_obs();
    f1 = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h01, 8'hAA, 8'hBB};
    f2 = '{8'hA5, 8'h03, 8'h04, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef CFG_CHECKSUM_EN
    f1.push_back(xor_all(f1));
    f2.push_back(xor_all(f2));
`endif
    foreach (f1[i]) send(f1[i], 0);
    send(f2[0], 0);
    send(f2[1], 0);
    check("b2b_layer_hold", 32'(config_layer_num), 32'd1);
    check("b2b_neuron_hold", 32'(config_neuron_num), 32'd2);
    send(f2[2], 0);
    check("b2b_layer_new", 32'(config_layer_num), 32'd3);
    check("b2b_neuron_new", 32'(config_neuron_num), 32'd4);
    for (int i = 3; i < f2.size(); i++) send(f2[i], 0);
    idle(3);
    check("b2b_n_weight", 32'(got_w_q.size()), 32'd3);
    if (got_w_q.size() == 3) begin
      check("b2b_w0", 32'(got_w_q[0]), 32'h0000AABB);
      check("b2b_w1", 32'(got_w_q[1]), 32'h00001122);
      check("b2b_w2", 32'(got_w_q[2]), 32'h00003344);
    end
    check("b2b_done", 32'(got_done), 32'd2);
    check("b2b_err", 32'(got_err), 32'd0);

    // Asynchronous reset in the middle of a 3-word frame
    clear_obs();
    f1 = '{8'hA5, 8'h02, 8'h07, 8'h00, 8'h03, 8'h10, 8'h01, 8'h20, 8'h02};
    foreach (f1[i]) send(f1[i], 0);
    check("mid_strobe", 32'(weightValid), 32'd1);
    check("mid_value", 32'(weightValue), 32'h00002002);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_weightValid", 32'(weightValid), 32'd0);
    check("mid_rst_weightValue", 32'(weightValue), 32'd0);
    check("mid_rst_layer", 32'(config_layer_num), 32'd0);
    check("mid_rst_neuron", 32'(config_neuron_num), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_layer = 16'd0;
    exp_neuron = 16'd0;
    stream_q = '{8'hA5, 8'h03, 8'h01, 8'h00, 8'h01, 8'h55, 8'h66};
`ifdef CFG_CHECKSUM_EN
    stream_q.push_back(xor_all(stream_q));
`endif
    run_stream("post_rst", 0);

`ifdef CFG_CHECKSUM_EN
    // Checksum match and mismatch on a single bias frame
    stream_q = '{8'h5B, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h10, 8'h4B};
    clear_obs();
    foreach (stream_q[i]) send(stream_q[i], 0);
    idle(3);
    check("chk_ok_bias", 32'(got_b_q.size()), 32'd1);
    check("chk_ok_done", 32'(got_done), 32'd1);
    check("chk_ok_err", 32'(got_err), 32'd0);
    stream_q[7] = 8'h4A;
    clear_obs();
    foreach (stream_q[i]) send(stream_q[i], 0);
    idle(3);
    check("chk_bad_bias", 32'(got_b_q.size()), 32'd1);
    check("chk_bad_done", 32'(got_done), 32'd0);
    check("chk_bad_err", 32'(got_err), 32'd1);
    stream_q.delete();
`endif

    // Random frame mixes under the three gap patterns
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 15; k++) gen_frame(int'($urandom_range(0, 5)), 6);
      run_stream("rand", g);
    end

    // Largest legal weight frame followed by a short bias frame
    gen_frame(0, 1);
    stream_q.delete();
    stream_q = '{8'hA5, 8'h01, 8'h05, 8'h03, 8'h10};
    for (int k = 0; k < 2 * 784; k++) stream_q.push_back(8'($urandom));
`ifdef CFG_CHECKSUM_EN
    stream_q.push_back(xor_all(stream_q));
`endif
    gen_frame(1, 1);
    run_stream("max_words", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
